// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI data-lane delay calibration block:
// FSM state encoding, tap geometry and the eye-centre helper.
package mipi_pkg;

   localparam int TAP_W     = 5;
   localparam int TAP_COUNT = 32;
   localparam int EYE_W     = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_MEASURE,
      ST_EVAL,
      ST_APPLY,
      ST_FINISH
   } state_e;

   // Centre of a passing run, rounded down; only meaningful for len >= 1.
   function automatic logic [TAP_W-1:0] eye_center(input logic [TAP_W-1:0] first,
                                                   input logic [EYE_W-1:0] len);
      logic [EYE_W-1:0] half;
      half = (len - EYE_W'(1)) >> 1;
      return first + half[TAP_W-1:0];
   endfunction

endpackage

// File: rtl/mipi_eye_tracker.sv
// Tracks the longest run of consecutive passing taps, scanned from tap 0 upward.
// The tap index is implied by the number of valid strobes since clear.
module mipi_eye_tracker
   import mipi_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             valid,
   input  logic             pass,
   output logic [TAP_W-1:0] best_start,
   output logic [EYE_W-1:0] best_len
);

   logic [TAP_W-1:0] idx_q, idx_d;
   logic [TAP_W-1:0] cur_start_q, cur_start_d;
   logic [EYE_W-1:0] cur_len_q, cur_len_d;
   logic [TAP_W-1:0] best_start_q, best_start_d;
   logic [EYE_W-1:0] best_len_q, best_len_d;
   logic [TAP_W-1:0] run_start;
   logic [EYE_W-1:0] run_len;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      idx_d        = idx_q;
      cur_start_d  = cur_start_q;
      cur_len_d    = cur_len_q;
      best_start_d = best_start_q;
      best_len_d   = best_len_q;
      run_start    = (cur_len_q == '0) ? idx_q : cur_start_q;
      run_len      = cur_len_q + EYE_W'(1);
      if (clear) begin
         idx_d        = '0;
         cur_start_d  = '0;
         cur_len_d    = '0;
         best_start_d = '0;
         best_len_d   = '0;
      end else if (valid) begin
         idx_d = idx_q + TAP_W'(1);
         if (pass) begin
            cur_start_d = run_start;
            cur_len_d   = run_len;
            // Strictly longer only, so the lowest-start run wins a tie.
            if (run_len > best_len_q) begin
               best_start_d = run_start;
               best_len_d   = run_len;
            end
         end else begin
            cur_len_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use non-blocking assignments so all update together at the edge.
      if (reset) begin
         idx_q        <= '0;
         cur_start_q  <= '0;
         cur_len_q    <= '0;
         best_start_q <= '0;
         best_len_q   <= '0;
      end else begin
         idx_q        <= idx_d;
         cur_start_q  <= cur_start_d;
         cur_len_q    <= cur_len_d;
         best_start_q <= best_start_d;
         best_len_q   <= best_len_d;
      end
   end

   assign best_start = best_start_q;
   assign best_len   = best_len_q;

endmodule

// File: rtl/mipi_delay_cal.sv
// Data-lane delay calibration: sweeps all taps, counts sync hits per tap and
// centres the delay in the widest passing eye. MIPI_DELAY_CAL_MAP_EN adds pass_map.
module mipi_delay_cal
   import mipi_pkg::*;
#(
   parameter int SETTLE_CYCLES = 64,
   parameter int WINDOW_CYCLES = 4096,
   parameter int MIN_HITS      = 4,
   parameter int MIN_EYE       = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sync_hit,
   input  logic             locked,
   output logic             del_ld,
   output logic [TAP_W-1:0] del_val,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [EYE_W-1:0] eye_width
`ifdef MIPI_DELAY_CAL_MAP_EN
   ,
   output logic [TAP_COUNT-1:0] pass_map
`endif
);

   localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(TAP_COUNT - 1);

   state_e           state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hits_q, hits_d;
   logic [TAP_W-1:0] save_q, save_d;
   logic             abort_q, abort_d;
   logic             del_ld_q, del_ld_d;
   logic [TAP_W-1:0] del_val_q, del_val_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;
   logic [EYE_W-1:0] eye_width_q, eye_width_d;
`ifdef MIPI_DELAY_CAL_MAP_EN
   logic [TAP_COUNT-1:0] map_q, map_d;
`endif

   logic             accept;
   logic             tap_pass;
   logic [TAP_W-1:0] best_start;
   logic [EYE_W-1:0] best_len;

   assign accept   = (state_q == ST_IDLE) && start && locked && !busy_q;
   assign tap_pass = (hits_q >= 8'(MIN_HITS));

   mipi_eye_tracker u_tracker (
      .clk        (clk),
      .reset      (reset),
      .clear      (accept),
      .valid      (state_q == ST_EVAL),
      .pass       (tap_pass),
      .best_start (best_start),
      .best_len   (best_len)
   );

   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      cnt_d       = cnt_q;
      hits_d      = hits_q;
      save_d      = save_q;
      abort_d     = abort_q;
      del_ld_d    = 1'b0;
      del_val_d   = del_val_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      fail_d      = fail_q;
      eye_width_d = eye_width_q;
`ifdef MIPI_DELAY_CAL_MAP_EN
      map_d       = map_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            busy_d = accept;
            if (accept) begin
               state_d = ST_LOAD;
               tap_d   = '0;
               save_d  = del_val_q;
               abort_d = 1'b0;
               fail_d  = 1'b0;
`ifdef MIPI_DELAY_CAL_MAP_EN
               map_d   = '0;
`endif
            end
         end
         ST_LOAD: begin
            del_ld_d  = 1'b1;
            del_val_d = tap_q;
            cnt_d     = '0;
            hits_d    = '0;
            state_d   = ST_SETTLE;
         end
         ST_SETTLE: begin
            hits_d = '0;
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_MEASURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MEASURE: begin
            if (sync_hit && locked && (hits_q != 8'hFF)) hits_d = hits_q + 8'd1;
            if (cnt_q == WINDOW_LAST) state_d = ST_EVAL;
            else                      cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_EVAL: begin
`ifdef MIPI_DELAY_CAL_MAP_EN
            map_d[tap_q] = tap_pass;
`endif
            if (tap_q == TAP_LAST) begin
               state_d = ST_APPLY;
            end else begin
               tap_d   = tap_q + TAP_W'(1);
               state_d = ST_LOAD;
            end
         end
         ST_APPLY: begin
            del_ld_d = 1'b1;
            if (!abort_q && (best_len >= EYE_W'(MIN_EYE))) begin
               del_val_d = eye_center(best_start, best_len);
               fail_d    = 1'b0;
            end else begin
               del_val_d = save_q;
               fail_d    = 1'b1;
            end
            state_d = ST_FINISH;
         end
         ST_FINISH: begin
            done_d      = 1'b1;
            eye_width_d = best_len;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Losing lock during the sweep abandons it and restores the pre-start delay.
      if (!locked && (state_q inside {ST_LOAD, ST_SETTLE, ST_MEASURE, ST_EVAL})) begin
         state_d   = ST_APPLY;
         abort_d   = 1'b1;
         tap_d     = tap_q;
         del_ld_d  = 1'b0;
         del_val_d = del_val_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tap_q       <= '0;
         cnt_q       <= '0;
         hits_q      <= '0;
         save_q      <= '0;
         abort_q     <= 1'b0;
         del_ld_q    <= 1'b0;
         del_val_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         eye_width_q <= '0;
`ifdef MIPI_DELAY_CAL_MAP_EN
         map_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         cnt_q       <= cnt_d;
         hits_q      <= hits_d;
         save_q      <= save_d;
         abort_q     <= abort_d;
         del_ld_q    <= del_ld_d;
         del_val_q   <= del_val_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
         eye_width_q <= eye_width_d;
`ifdef MIPI_DELAY_CAL_MAP_EN
         map_q       <= map_d;
`endif
      end
   end

   assign del_ld    = del_ld_q;
   assign del_val   = del_val_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;
   assign eye_width = eye_width_q;
`ifdef MIPI_DELAY_CAL_MAP_EN
   assign pass_map  = map_q;
`endif

endmodule

// File: tb/tb_mipi_delay_cal.sv
// Scoreboard bench for mipi_delay_cal: per-tap sync_hit patterns, expected
// results queued at start and compared when done pulses.
module tb_mipi_delay_cal;

   localparam int SETTLE   = 4;
   localparam int WINDOW   = 300;
   localparam int MIN_HITS = 4;
   localparam int MIN_EYE  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       sync_hit = 1'b0;
   logic       locked = 1'b1;
   logic       del_ld;
   logic [4:0] del_val;
   logic       busy;
   logic       done;
   logic       fail;
   logic [5:0] eye_width;
`ifdef MIPI_DELAY_CAL_MAP_EN
   logic [31:0] pass_map;
`endif

   always #5 clk = ~clk;

   mipi_delay_cal #(
      .SETTLE_CYCLES (SETTLE),
      .WINDOW_CYCLES (WINDOW),
      .MIN_HITS      (MIN_HITS),
      .MIN_EYE       (MIN_EYE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sync_hit  (sync_hit),
      .locked    (locked),
      .del_ld    (del_ld),
      .del_val   (del_val),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .eye_width (eye_width)
`ifdef MIPI_DELAY_CAL_MAP_EN
      ,
      .pass_map  (pass_map)
`endif
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // ---------------- sync_hit driver: pattern per tap, starts 2 cycles into MEASURE
   int pat_n[32];
   bit pat_hold[32];
   int drv_delay = 0;
   int drv_left  = 0;
   bit drv_hold  = 1'b0;

   always @(negedge clk) begin
      if (drv_delay > 0) begin
         sync_hit = 1'b0;
         drv_delay--;
      end else if (drv_left > 0) begin
         if (drv_hold) begin
            sync_hit = 1'b1;
            drv_left--;
         end else if (sync_hit) begin
            sync_hit = 1'b0;
         end else begin
            sync_hit = 1'b1;
            drv_left--;
         end
      end else begin
         sync_hit = 1'b0;
      end
      if (del_ld === 1'b1 && pat_n[del_val] > 0) begin
         drv_delay = SETTLE + 1;
         drv_left  = pat_n[del_val];
         drv_hold  = pat_hold[del_val];
      end
   end

   // ---------------- scoreboard
   typedef struct {
      logic [4:0]  val;
      logic        fail;
      logic [5:0]  eye;
      int          ld;
      logic [31:0] map;
   } exp_t;

   exp_t sb_q[$];
   int   ld_cnt   = 0;
   int   done_cnt = 0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         ld_cnt = 0;
      end else begin
         if (del_ld) ld_cnt++;
         if (done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
               check("spurious_done", done, 1'b0);
            end else begin
               e = sb_q.pop_front();
               check("del_val", del_val, e.val);
               check("fail", fail, e.fail);
               check("eye_width", eye_width, e.eye);
               check("busy_at_done", busy, 1'b1);
               check("del_ld_count", ld_cnt, e.ld);
`ifdef MIPI_DELAY_CAL_MAP_EN
               check("pass_map", pass_map, e.map);
`endif
            end
            ld_cnt = 0;
         end
      end
   end

   // ---------------- helpers
   task automatic clear_pat();
      for (int i = 0; i < 32; i++) begin
         pat_n[i]    = 0;
         pat_hold[i] = 1'b0;
      end
   endtask

   task automatic set_range(input int lo, input int hi, input int n, input bit hold);
      for (int i = lo; i <= hi; i++) begin
         pat_n[i]    = n;
         pat_hold[i] = hold;
      end
   endtask

   // Hits seen per tap: held patterns lose the first 2 window cycles, counter saturates.
   function automatic logic [31:0] calc_map();
      logic [31:0] m;
      int h;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         h = pat_hold[i] ? ((pat_n[i] < WINDOW - 2) ? pat_n[i] : WINDOW - 2) : pat_n[i];
         if (h > 255) h = 255;
         m[i] = (h >= MIN_HITS);
      end
      return m;
   endfunction

   task automatic push_exp(input logic [4:0] val, input logic f, input logic [5:0] eye, input int ld);
      exp_t e;
      e.val  = val;
      e.fail = f;
      e.eye  = eye;
      e.ld   = ld;
      e.map  = calc_map();
      sb_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int prev, input int budget);
      int k;
      k = 0;
      while (done_cnt == prev && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == prev) check("done_timeout", done_cnt, prev + 1);
   endtask

   task automatic wait_drv_idle();
      int k;
      k = 0;
      while ((drv_left != 0 || drv_delay != 0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_ld_tap(input int tap, input int budget, input string tag);
      int k;
      k = 0;
      while (!(del_ld === 1'b1 && del_val == 5'(tap)) && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) check(tag, del_val, 5'(tap));
   endtask

   task automatic run_cal(input logic [4:0] val, input logic f, input logic [5:0] eye, input int ld);
      int prev;
      push_exp(val, f, eye, ld);
      prev = done_cnt;
      pulse_start();
      check("busy_rise", busy, 1'b1);
      wait_done(prev, 12000);
      wait_drv_idle();
   endtask

   // ---------------- stimulus
   initial begin
      int prev;
      int seen;
      clear_pat();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_del_ld", del_ld, 1'b0);
      check("rst_del_val", del_val, 5'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_fail", fail, 1'b0);
      check("rst_eye", eye_width, 6'd0);

      // start without lock is ignored
      locked = 1'b0;
      pulse_start();
      repeat (10) @(negedge clk);
      check("nolock_busy", busy, 1'b0);
      check("nolock_ld", ld_cnt, 0);
      locked = 1'b1;
      repeat (2) @(negedge clk);

      // eye 10..20 -> centre 15
      clear_pat();
      set_range(10, 20, 8, 1'b0);
      run_cal(5'd15, 1'b0, 6'd11, 33);

      // equal runs 2..5 / 20..23, tap 2 exactly MIN_HITS, tap 6 one short
      clear_pat();
      set_range(2, 2, 4, 1'b0);
      set_range(3, 5, 8, 1'b0);
      set_range(6, 6, 3, 1'b0);
      set_range(20, 23, 8, 1'b0);
      run_cal(5'd3, 1'b0, 6'd4, 33);

      // run of exactly MIN_EYE 6..8 -> centre 7
      clear_pat();
      set_range(6, 8, 8, 1'b0);
      run_cal(5'd7, 1'b0, 6'd3, 33);

      // eye too narrow -> keep 7, fail
      clear_pat();
      set_range(0, 1, 8, 1'b0);
      run_cal(5'd7, 1'b1, 6'd2, 33);

      // top taps with held sync_hit; tap 30 gets exactly 256 hits (wrap would fail it)
      clear_pat();
      set_range(29, 29, 300, 1'b1);
      set_range(30, 30, 256, 1'b1);
      set_range(31, 31, 300, 1'b1);
      run_cal(5'd30, 1'b0, 6'd3, 33);

      // lock lost during tap 12 MEASURE
      clear_pat();
      set_range(3, 6, 8, 1'b0);
      push_exp(5'd30, 1'b1, 6'd4, 14);
      prev = done_cnt;
      pulse_start();
      check("busy_rise_abort", busy, 1'b1);
      wait_ld_tap(12, 6000, "tap12_timeout");
      repeat (10) @(negedge clk);
      locked = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("abort_apply_ld", del_ld, 1'b1);
      check("abort_apply_val", del_val, 5'd30);
      wait_done(prev, 20);
      repeat (20) @(negedge clk);
      check("abort_one_done", done_cnt, prev + 1);
      locked = 1'b1;
      wait_drv_idle();

      // second start while busy, then reset mid-SETTLE
      clear_pat();
      prev = done_cnt;
      pulse_start();
      check("busy_rise_rst", busy, 1'b1);
      wait_ld_tap(0, 50, "tap0_timeout");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (del_ld) seen++;
      end
      check("restart_ignored", seen, 0);
      wait_ld_tap(1, 1000, "tap1_timeout");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_del_ld", del_ld, 1'b0);
      check("mid_rst_del_val", del_val, 5'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_fail", fail, 1'b0);
      check("mid_rst_eye", eye_width, 6'd0);
      repeat (400) @(negedge clk);
      check("mid_rst_no_done", done_cnt, prev);
      check("mid_rst_no_ld", ld_cnt, 0);
      check("mid_rst_idle", busy, 1'b0);
      check("sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
